// File: rtl/vga_pkg.sv
// vga_pkg
//   Shared constants for the 640x480@60 VGA raster (800x525 total, 25 MHz
//   pixel clock) and the geometry of the 512x256 Hack screen that is
//   centred inside it. Also carries the bundle type that the timing
//   generator hands to the scanout logic.
package vga_pkg;

  typedef logic [9:0] coord_t;

  // Horizontal timing, in pixel clocks from the start of the visible area.
  localparam coord_t H_TOTAL      = 10'd800;
  localparam coord_t H_VISIBLE    = 10'd640;
  localparam coord_t H_SYNC_START = 10'd656;
  localparam coord_t H_SYNC_END   = 10'd752;

  // Vertical timing, in lines.
  localparam coord_t V_TOTAL      = 10'd525;
  localparam coord_t V_VISIBLE    = 10'd480;
  localparam coord_t V_SYNC_START = 10'd490;
  localparam coord_t V_SYNC_END   = 10'd492;

  // Hack screen geometry: 512x256 pixels, 32 16-bit words per row.
  localparam int HACK_WIDTH         = 512;
  localparam int HACK_HEIGHT        = 256;
  localparam int HACK_WORDS_PER_ROW = 32;
  localparam int HACK_WORD_BITS     = 16;
  localparam int VRAM_ADDR_W        = 13;

  typedef struct packed {
    coord_t hcount;
    coord_t vcount;
    logic   hsync;
    logic   vsync;
    logic   active;
  } vga_timing_t;

endpackage

// File: rtl/vga_timing.sv
// vga_timing
//   Raster counters and sync/active decode for 640x480@60.
//   Ports:
//     clk    - pixel clock
//     reset  - synchronous, active high; returns the raster to (0,0)
//     timing - current hcount/vcount plus hsync, vsync (active low) and
//              active, all decoded from the counter registers this cycle
module vga_timing
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output vga_timing_t timing
);

  coord_t hcount_q, hcount_d;
  coord_t vcount_q, vcount_d;

  always_comb begin
    hcount_d = hcount_q + 10'd1;
    vcount_d = vcount_q;
    if (hcount_q == H_TOTAL - 10'd1) begin
      hcount_d = '0;
      vcount_d = (vcount_q == V_TOTAL - 10'd1) ? '0 : vcount_q + 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hcount_q <= '0;
      vcount_q <= '0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
    end
  end

  always_comb begin
    timing.hcount = hcount_q;
    timing.vcount = vcount_q;
    timing.hsync  = !((hcount_q >= H_SYNC_START) && (hcount_q < H_SYNC_END));
    timing.vsync  = !((vcount_q >= V_SYNC_START) && (vcount_q < V_SYNC_END));
    timing.active = (hcount_q < H_VISIBLE) && (vcount_q < V_VISIBLE);
  end

endmodule

// File: rtl/vram_scanout.sv
// vram_scanout
//   Scans the Hack 512x256 monochrome frame buffer out of VRAM onto a
//   640x480 VGA raster, with the Hack window placed at (H_OFFSET, V_OFFSET).
//   Each 16-pixel word is fetched in the two cycles before it is displayed;
//   the RAM's registered output is captured at the end of the second cycle
//   and then shifted out LSB first (LSB = leftmost pixel).
//   Ports:
//     clk, reset  - pixel clock, synchronous active-high reset
//     p_read      - VRAM read request (stalls the CPU port while high)
//     p_addr      - VRAM word address, 0 whenever p_read is low
//     p_dout      - VRAM read data, only meaningful while p_read is high
//     hsync/vsync - active-low syncs
//     active      - high inside the 640x480 visible area
//     pixel       - Hack pixel, 0 outside the Hack window
//     frame_start - one-cycle pulse at (0,480); present only when
//                   VRAM_SCANOUT_FRAME_PULSE_EN is defined
module vram_scanout
  import vga_pkg::*;
#(
  parameter int H_OFFSET = 64,
  parameter int V_OFFSET = 112
) (
  input  logic        clk,
  input  logic        reset,
  output logic        p_read,
  output logic [12:0] p_addr,
  input  logic [15:0] p_dout,
  output logic        hsync,
  output logic        vsync,
  output logic        active,
  output logic        pixel
`ifdef VRAM_SCANOUT_FRAME_PULSE_EN
  ,
  output logic        frame_start
`endif
);

  // Fetch slots span Xk-2 .. Xk-1 for k = 0..31, i.e. from H_OFFSET-2 up to
  // the cycle before the last word's first pixel.
  localparam coord_t FETCH_LO = coord_t'(H_OFFSET - 2);
  localparam coord_t FETCH_HI = coord_t'(H_OFFSET + HACK_WIDTH - 17);
  localparam coord_t WIN_H_LO = coord_t'(H_OFFSET);
  localparam coord_t WIN_H_HI = coord_t'(H_OFFSET + HACK_WIDTH - 1);
  localparam coord_t WIN_V_LO = coord_t'(V_OFFSET);
  localparam coord_t WIN_V_HI = coord_t'(V_OFFSET + HACK_HEIGHT - 1);

  vga_timing_t timing;

  vga_timing u_timing (
    .clk    (clk),
    .reset  (reset),
    .timing (timing)
  );

  logic        win_line;
  logic        win_col;
  logic        in_window;
  logic        in_fetch;
  logic        load;
  logic [8:0]  fetch_rel;
  logic [7:0]  row;
  logic [4:0]  word_idx;
  logic [15:0] shift_q, shift_d;

  always_comb begin
    win_line  = (timing.vcount >= WIN_V_LO) && (timing.vcount <= WIN_V_HI);
    win_col   = (timing.hcount >= WIN_H_LO) && (timing.hcount <= WIN_H_HI);
    in_window = win_line && win_col;
    // Offset from the first fetch slot: bits [8:4] name the word being
    // fetched, bits [3:1] == 0 marks its two-cycle slot, bit 0 the second.
    fetch_rel = 9'(timing.hcount - FETCH_LO);
    row       = 8'(timing.vcount - WIN_V_LO);
    word_idx  = fetch_rel[8:4];
    in_fetch  = win_line && (timing.hcount >= FETCH_LO) &&
                (timing.hcount <= FETCH_HI) && (fetch_rel[3:1] == 3'd0);
    load      = in_fetch && fetch_rel[0];
  end

  // The load of word k+1 lands on the edge ending pixel Xk+15, so it takes
  // priority over the shift that would otherwise happen there.
  always_comb begin
    shift_d = shift_q;
    if (load) begin
      shift_d = p_dout;
    end else if (in_window) begin
      shift_d = {1'b0, shift_q[15:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign p_read = in_fetch;
  assign p_addr = in_fetch ? {row, word_idx} : 13'd0;
  assign hsync  = timing.hsync;
  assign vsync  = timing.vsync;
  assign active = timing.active;
  assign pixel  = in_window && shift_q[0];

`ifdef VRAM_SCANOUT_FRAME_PULSE_EN
  assign frame_start = !reset && (timing.hcount == 10'd0) &&
                       (timing.vcount == V_VISIBLE);
`endif

endmodule

// File: tb/tb_vram_scanout.sv
// tb_vram_scanout
//   Drives vram_scanout against a behavioural VRAM filled with random words
//   and compares every output on every cycle with a raster model computed
//   from pixel/line arithmetic. Literal expectations pin the first and last
//   Hack words, sync widths, line/frame periods and the mid-line reset.
module tb_vram_scanout;

  localparam int HO = 64;
  localparam int VO = 112;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        p_read;
  logic [12:0] p_addr;
  logic [15:0] p_dout = 16'd0;
  logic        hsync;
  logic        vsync;
  logic        active;
  logic        pixel;
`ifdef VRAM_SCANOUT_FRAME_PULSE_EN
  logic        frame_start;
`endif

  vram_scanout #(
    .H_OFFSET (HO),
    .V_OFFSET (VO)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .p_read (p_read),
    .p_addr (p_addr),
    .p_dout (p_dout),
    .hsync  (hsync),
    .vsync  (vsync),
    .active (active),
    .pixel  (pixel)
`ifdef VRAM_SCANOUT_FRAME_PULSE_EN
    ,
    .frame_start (frame_start)
`endif
  );

  always #20 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:8191];

  // Model raster position and cycles since the last reset release.
  int mh = 0;
  int mv = 0;
  int ncyc = 0;
  bit run_chk = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (line %0d col %0d): got %0h expected %0h", name, mv, mh, act, exp);
      if (errors >= 50) begin
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  endtask

  // Outputs packed as {hsync, vsync, active, p_read, p_addr[12:0], pixel}.
  function automatic logic [17:0] model_out(input int h, input int v);
    logic hs, vs, act, rd, pix;
    int   addr;
    int   row;
    int   x;
    hs   = !(h >= 656 && h <= 751);
    vs   = !(v >= 490 && v <= 491);
    act  = (h < 640) && (v < 480);
    rd   = 1'b0;
    pix  = 1'b0;
    addr = 0;
    if (v >= VO && v < VO + 256) begin
      row = v - VO;
      for (int k = 0; k < 32; k++) begin
        x = HO + 16 * k;
        if (h == x - 2 || h == x - 1) begin
          rd   = 1'b1;
          addr = row * 32 + k;
        end
        if (h >= x && h < x + 16) pix = mem[row * 32 + k][h - x];
      end
    end
    return {hs, vs, act, rd, 13'(addr), pix};
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      mh = 0;
      mv = 0;
      ncyc = 0;
    end else begin
      ncyc++;
      if (mh == 799) begin
        mh = 0;
        mv = (mv == 524) ? 0 : mv + 1;
      end else begin
        mh++;
      end
    end
  end

  logic [17:0] exp_o;
  logic prev_hs = 1'b1, prev_vs = 1'b1, prev_act = 1'b1;
  int   hs_low = 0, vs_low = 0, inact_len = 0, last_fall = -1;
  int   rd_cnt = 0, pix_cnt = 0, frame_rises = 0;
  int   fs_pulses = 0, fs_cyc = -1;

  always @(negedge clk) begin
    if (run_chk) begin
      exp_o = model_out(mh, mv);
      check("scan_out", 32'({hsync, vsync, active, p_read, p_addr, pixel}), 32'(exp_o));
`ifdef VRAM_SCANOUT_FRAME_PULSE_EN
      check("frame_start", 32'(frame_start), 32'(!reset && mh == 0 && mv == 480));
      if (mh == 0 && mv == 480 && !reset) check("frame_start_at_0_480", 32'(frame_start), 1);
      if (frame_start) begin
        fs_pulses++;
        fs_cyc = ncyc;
      end
`endif
      if (reset) begin
        hs_low = 0; vs_low = 0; inact_len = 0; last_fall = -1;
        fs_pulses = 0; fs_cyc = -1;
      end else begin
        if (!hsync && prev_hs) begin
          if (last_fall >= 0) check("line_period", 32'(ncyc - last_fall), 800);
          last_fall = ncyc;
        end
        if (hsync && !prev_hs) check("hsync_width", 32'(hs_low), 96);
        if (vsync && !prev_vs) check("vsync_width", 32'(vs_low), 1600);
        if (active && !prev_act && inact_len > 200) begin
          frame_rises++;
          check("frame_period", 32'(ncyc), 420000);
        end
        hs_low    = hsync ? 0 : hs_low + 1;
        vs_low    = vsync ? 0 : vs_low + 1;
        inact_len = active ? 0 : inact_len + 1;
      end
      prev_hs  = hsync;
      prev_vs  = vsync;
      prev_act = active;

      if (mv == 112) begin
        if (mh == 61) check("l112_idle_61", 32'(p_read), 0);
        if (mh == 62 || mh == 63) begin
          check("l112_p_read", 32'(p_read), 1);
          check("l112_p_addr", 32'(p_addr), 0);
        end
        if (mh == 64) check("l112_pix64", 32'(pixel), 1);
        if (mh >= 65 && mh <= 79) check("l112_pix_word0", 32'(pixel), 0);
      end
      if (mv == 367) begin
        if (mh == 558 || mh == 559) begin
          check("l367_p_read", 32'(p_read), 1);
          check("l367_p_addr", 32'(p_addr), 8191);
        end
        if (mh >= 560 && mh <= 574) check("l367_pix_word31", 32'(pixel), 0);
        if (mh == 575) check("l367_pix575", 32'(pixel), 1);
        if (mh == 576) check("l367_pix576", 32'(pixel), 0);
      end

      if (mh == 0) begin
        rd_cnt = 0;
        pix_cnt = 0;
      end
      rd_cnt  += int'(p_read);
      pix_cnt += int'(pixel);
      if (mh == 799 && !reset) begin
        if (mv == 111 || mv == 368) begin
          check("no_fetch_line", 32'(rd_cnt), 0);
          check("no_pixel_line", 32'(pix_cnt), 0);
        end
        if (mv >= VO && mv < VO + 256) check("fetch_duty", 32'(rd_cnt), 64);
      end
    end
    // Read data is only valid while p_read is high; otherwise drive noise.
    p_dout = p_read ? mem[p_addr] : 16'($urandom);
  end

  task automatic post_reset_checks(input string tag);
    check({tag, "_hsync"},  32'(hsync),  1);
    check({tag, "_vsync"},  32'(vsync),  1);
    check({tag, "_active"}, 32'(active), 1);
    check({tag, "_pixel"},  32'(pixel),  0);
    check({tag, "_p_read"}, 32'(p_read), 0);
    check({tag, "_p_addr"}, 32'(p_addr), 0);
    check({tag, "_hcount"}, 32'(dut.u_timing.hcount_q), 0);
    check({tag, "_vcount"}, 32'(dut.u_timing.vcount_q), 0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 8192; i++) mem[i] = 16'($urandom);
    mem[0]    = 16'h0001;
    mem[8191] = 16'h8000;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    post_reset_checks("por");
    run_chk = 1'b1;

    // Free run into the window, then reset in the middle of line 200.
    n = 0;
    while (!(mv == 200 && mh == 300) && n < 200000) begin
      @(negedge clk);
      n++;
    end
    check("reach_200_300", 32'(mv == 200 && mh == 300), 1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    post_reset_checks("mid_reset");

    // One complete frame from the restart, through the wrap to line 0.
    n = 0;
    while (frame_rises == 0 && n < 430000) begin
      @(negedge clk);
      n++;
    end
    check("frame_wrap_seen", 32'(frame_rises), 1);
    repeat (10) @(negedge clk);
`ifdef VRAM_SCANOUT_FRAME_PULSE_EN
    check("frame_start_pulses", 32'(fs_pulses), 1);
    check("frame_start_cycle", 32'(fs_cyc), 384000);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
